cpu_trace_buffer: RTL
=====================

Name: cpu_trace_buffer

Overview:
- Downstream observer of the single-cycle CPU top.
- Consumes the per-cycle retire outputs (PC, Inst, R) and records them into a circular trace RAM, with a PC-match trigger and a fixed post-trigger window.
- Stored entries are then drained over a valid/ready read port to a debug/UART stage.
- Used in simulation and on-board to inspect the last N instructions around an event.

Parameters:
- DEPTH, 16: trace entries; power of two.
- AW, 4: log2(DEPTH); pointer width.
- POST_TRIG, 8: entries captured after the trigger entry; 0 ≤ POST_TRIG < DEPTH.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  synchronous active-high reset.
- Cap_en  in  1  CPU retired an instruction this cycle; sample PC/Inst/R.
- PC  in  32  PC of the retiring instruction.
- Inst  in  32  retiring instruction word.
- R  in  32  ALU/writeback result of the retiring instruction.
- Arm  in  1  one-cycle pulse; starts capture from IDLE.
- Trig_pc  in  32  trigger PC value.
- Rd_ready  in  1  consumer accepts Rd_data.
- Rd_valid  out  1  Rd_data holds a valid entry.
- Rd_data  out  96  {PC, Inst, R}, oldest entry first.
- Count  out  AW+1  entries currently stored.
- Dropped  out  1  sticky; pre-trigger data was overwritten.
- State  out  2  FSM state encoding.

Behaviour:
- Reset:
  - Rst=1 at a rising edge gives State=IDLE, Count=0, Rd_valid=0, Rd_data=0, Dropped=0, and wr/rd pointers=0.
  - Reset mid-capture or mid-drain discards all entries. RAM contents are not cleared.
- FSM states: IDLE=0, ARMED=1, POST=2, DONE=3.
- IDLE:
  - No writes.
  - Arm=1 moves to ARMED and clears Count, pointers and Dropped in the same edge.
- ARMED:
  - Each Cap_en cycle writes {PC,Inst,R} at wr_ptr, then wr_ptr+1 mod DEPTH.
  - Writing while Count==DEPTH overwrites the oldest entry: rd_ptr advances, Count stays DEPTH, Dropped is set.
  - Cap_en=1 with PC==Trig_pc writes that entry (the trigger entry), loads post counter=POST_TRIG, then goes to POST.
  - If POST_TRIG==0, it goes directly to DONE instead.
  - Arm is ignored outside IDLE.
- POST:
  - Each Cap_en write decrements the post counter, with the same overwrite rule as ARMED.
  - The write that brings the counter to 0 moves to DONE.
  - Trig_pc matches are ignored.
- DONE:
  - No writes; Cap_en is ignored.
  - Rd_valid=1 whenever Count>0, with Rd_data=RAM[rd_ptr] (registered output, valid the cycle after entry into DONE).
  - Each cycle with Rd_valid && Rd_ready: rd_ptr+1 mod DEPTH, Count−1.
  - When the final entry is accepted (Count 1→0): Rd_valid drops the next cycle and the FSM returns to IDLE.
  - DONE with Count==0 (impossible except via trigger on an empty buffer; the trigger entry itself makes Count ≥1) returns to IDLE.
- Read protocol:
  - Rd_valid/Rd_data stay stable until accepted.
  - Rd_valid is never asserted outside DONE.
- Timing:
  - Capture latency is one cycle: a Cap_en cycle is reflected in Count at the next edge.
  - Throughput is one entry per cycle in both directions.
- Pointer arithmetic is modulo DEPTH. Count saturates at DEPTH and never wraps.

Optional Feature:
- Macro: TRACE_TSTAMP_EN.
- Defined:
  - A 16-bit free-running cycle counter (reset 0, wraps 0xFFFF→0) is stored with each entry.
  - Rd_data becomes 112 bits: {TS, PC, Inst, R}.
  - Consumers use it to detect stall gaps.
- Undefined:
  - No counter; Rd_data is 96 bits as above.

Decomposition:
- Shared package holds:
  - State encodings IDLE/ARMED/POST/DONE.
  - Entry field widths (PC_W=32, INST_W=32, R_W=32, TS_W=16).
  - The ENTRY_W derivation, conditional on TRACE_TSTAMP_EN.
- One sub-module: trace_ram. It is a simple dual-port RAM, DEPTH×ENTRY_W, with synchronous write and registered read, so it infers block RAM.
- The FSM, pointers and counters stay in cpu_trace_buffer.

Test Plan:
- Reset mid-POST: Arm, 5 writes, trigger, 2 writes, Rst=1 → next cycle State=0, Count=0, Rd_valid=0, Dropped=0.
- No wrap: Arm, Cap_en for 3 cycles with PC=0x00,0x04,0x08, Trig_pc=0x08, POST_TRIG=8, then 8 more retires PC=0x0C..0x28 → State=DONE, Count=11, reads return PC 0x00..0x28 in order, Dropped=0, then State=IDLE.
- Overwrite: Arm, 30 retires PC=0x00..0x74, trigger at 0x74, POST_TRIG=0 → Count=16, Dropped=1, first read PC=0x38, last PC=0x74.
- Backpressure: in DONE with Count=4, Rd_ready toggling 1,0,0,1,1,0,1 → exactly 4 accepts, Rd_data unchanged while Rd_ready=0, no duplicates or skips.
- Ignored inputs: Arm during POST and Cap_en during DONE → no state change, Count unchanged. Trig_pc match during POST → no re-trigger.
- TRACE_TSTAMP_EN defined: retires on cycles 10, 11, 15 after reset → TS fields 10, 11, 15.

Source files
------------

// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types for the CPU retire trace buffer.
// TRACE_TSTAMP_EN adds a 16-bit cycle stamp to every entry.
package cpu_trace_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int R_W    = 32;
  localparam int TS_W   = 16;

`ifdef TRACE_TSTAMP_EN
  localparam int ENTRY_W = TS_W + PC_W + INST_W + R_W;
`else
  localparam int ENTRY_W = PC_W + INST_W + R_W;
`endif

endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// Simple dual-port trace RAM: synchronous write, registered read.
// Only the read register is reset, so the array still maps to block RAM.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 96
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular retire trace with PC trigger and post-trigger window.
// Optional TRACE_TSTAMP_EN prepends a free-running cycle stamp.
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int POST_TRIG = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Cap_en,
  input  logic [31:0]        PC,
  input  logic [31:0]        Inst,
  input  logic [31:0]        R,
  input  logic               Arm,
  input  logic [31:0]        Trig_pc,
  input  logic               Rd_ready,
  output logic               Rd_valid,
  output logic [ENTRY_W-1:0] Rd_data,
  output logic [AW:0]        Count,
  output logic               Dropped,
  output logic [1:0]         State
);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_1   = (AW+1)'(1);
  localparam logic [AW-1:0] POST_1  = AW'(1);
  localparam logic [AW-1:0] POST_LD = AW'(POST_TRIG);

  state_t          state, state_n;
  logic [AW-1:0]   wr_ptr, wr_ptr_n;
  logic [AW-1:0]   rd_ptr, rd_ptr_n;
  logic [AW-1:0]   post_cnt, post_n;
  logic [AW:0]     count_n;
  logic            dropped_n;
  logic            wr, acc, full;
  logic [ENTRY_W-1:0] wdata;

`ifdef TRACE_TSTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge Clk) begin
    if (Rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  assign wdata = {ts, PC, Inst, R};
`else
  assign wdata = {PC, Inst, R};
`endif

  assign wr    = Cap_en && (state == ARMED || state == POST);
  assign acc   = Rd_valid && Rd_ready;
  assign full  = Count == FULL;
  assign State = state;

  always_comb begin
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    count_n   = Count;
    post_n    = post_cnt;
    dropped_n = Dropped;
    unique case (state)
      IDLE: if (Arm) begin
        state_n   = ARMED;
        wr_ptr_n  = '0;
        rd_ptr_n  = '0;
        count_n   = '0;
        dropped_n = 1'b0;
      end
      ARMED: if (Cap_en && PC == Trig_pc) begin
        post_n  = POST_LD;
        state_n = (POST_TRIG == 0) ? DONE : POST;
      end
      POST: if (Cap_en) begin
        post_n = post_cnt - 1'b1;
        if (post_cnt == POST_1) state_n = DONE;
      end
      DONE: if (Count == '0 || (acc && Count == CNT_1))
        state_n = IDLE;
      default: ;
    endcase
    // A full buffer drops its oldest entry to make room.
    if (wr) begin
      wr_ptr_n = wr_ptr + 1'b1;
      if (full) begin
        rd_ptr_n  = rd_ptr + 1'b1;
        dropped_n = 1'b1;
      end else begin
        count_n = Count + 1'b1;
      end
    end
    if (acc) begin
      rd_ptr_n = rd_ptr + 1'b1;
      count_n  = Count - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      Count    <= '0;
      Dropped  <= 1'b0;
      Rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      post_cnt <= post_n;
      Count    <= count_n;
      Dropped  <= dropped_n;
      Rd_valid <= (state_n == DONE) && (count_n != '0);
    end
  end

  // Reading at the next rd_ptr keeps the registered data one step ahead.
  trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_ram (
    .clk   (Clk),
    .rst   (Rst),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr_n),
    .rdata (Rd_data)
  );

endmodule
